uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/cmd_table_match.sv | 32 +++
 rtl/uart_cmd_decoder.sv | 118 +++++++++++
 tb/tb_uart_cmd_decoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: FSM encoding, ASCII constants
// and the default command character table.
package uart_cmd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_PULSE  = 2'd2;
  localparam state_t ST_ECHO   = 2'd3;

  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FOLD  = 8'h20;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;

  // Byte 0 is the rightmost character, so 'R' drives cmd_pulse[0].
  localparam logic [39:0] DEFAULT_CMD_CHARS = {"S", "M", "H", "C", "R"};

  function automatic logic [7:0] fold_upper(input logic [7:0] b);
    return ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) ? (b - ASCII_FOLD) : b;
  endfunction

endpackage

// File: rtl/cmd_table_match.sv
// Combinational lookup of one byte against the command table; the lowest
// matching index wins.
module cmd_table_match
  import uart_cmd_pkg::*;
#(
  parameter int                   NUM_CMD   = 5,
  parameter logic [NUM_CMD*8-1:0] CMD_CHARS = DEFAULT_CMD_CHARS,
  parameter bit                   CASE_FOLD = 1'b1,
  parameter int                   IDX_W     = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1
) (
  input  logic [7:0]       i_byte,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  logic [7:0] w_key;

  assign w_key = CASE_FOLD ? fold_upper(i_byte) : i_byte;

  // Scan from the top down so a lower index overrides any higher match.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_CMD - 1; i >= 0; i--) begin
      if (w_key == CMD_CHARS[8*i +: 8]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Pops bytes from an RX FIFO, decodes them into per-channel command pulses and
// optionally echoes an acknowledge byte into a TX FIFO.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int                   NUM_CMD   = 5,
  parameter logic [NUM_CMD*8-1:0] CMD_CHARS = DEFAULT_CMD_CHARS,
  parameter int                   PULSE_LEN = 1,
  parameter bit                   ECHO_EN   = 1'b1,
  parameter bit                   CASE_FOLD = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         fifo_rx_data,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic               tx_full,
  output logic               tx_wr_en,
  output logic [7:0]         tx_data,
  output logic [NUM_CMD-1:0] cmd_pulse,
  output logic [7:0]         err_cnt,
  output logic               busy
);

  localparam int     IDX_W   = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;
  localparam state_t ST_DONE = ECHO_EN ? ST_ECHO : ST_IDLE;

  state_t             r_state;
  logic [7:0]         r_byte;
  logic [NUM_CMD-1:0] r_pulse;
  logic [7:0]         r_pulse_cnt;
  logic [7:0]         r_tx_data;
  logic [7:0]         r_err_cnt;

  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [7:0]         w_char;
  logic               w_is_eol;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  cmd_table_match #(
    .NUM_CMD   (NUM_CMD),
    .CMD_CHARS (CMD_CHARS),
    .CASE_FOLD (CASE_FOLD),
    .IDX_W     (IDX_W)
  ) u_match (
    .i_byte (r_byte),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_char   = CMD_CHARS[int'(w_idx)*8 +: 8];
  assign w_is_eol = (r_byte == ASCII_CR) || (r_byte == ASCII_LF);

  // Strobes are gated by reset so nothing leaks out during the reset cycle itself.
  assign fifo_rd_en = !reset && (r_state == ST_IDLE) && !fifo_empty;
  assign tx_wr_en   = !reset && (r_state == ST_ECHO) && !tx_full;
  assign tx_data    = reset ? 8'h00 : r_tx_data;
  assign cmd_pulse  = reset ? '0 : r_pulse;
  assign err_cnt    = reset ? 8'h00 : r_err_cnt;
  assign busy       = !reset && (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (fifo_rd_en) begin
      r_byte <= fifo_rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pulse     <= '0;
      r_pulse_cnt <= 8'd0;
      r_tx_data   <= 8'h00;
      r_err_cnt   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_is_eol) begin
            r_state <= ST_IDLE;
          end else if (w_hit) begin
            r_state     <= ST_PULSE;
            r_pulse     <= NUM_CMD'(1) << w_idx;
            r_pulse_cnt <= 8'(PULSE_LEN - 1);
            r_tx_data   <= w_char;
          end else begin
            r_state   <= ST_DONE;
            r_err_cnt <= sat_inc8(r_err_cnt);
            r_tx_data <= ASCII_QMARK;
          end
        end
        ST_PULSE: begin
          if (r_pulse_cnt == 8'd0) begin
            r_pulse <= '0;
            r_state <= ST_DONE;
          end else begin
            r_pulse_cnt <= r_pulse_cnt - 8'd1;
          end
        end
        ST_ECHO: begin
          if (!tx_full) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench: three decoder instances (defaults; no case fold with 4-cycle
// pulses; 8-cycle pulses without echo), each fed by its own show-ahead FIFO model.
module tb_uart_cmd_decoder;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic tx_full = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] empty_r = 3'b111;
  logic [7:0] data_r  [3];
  logic [2:0] rd_w, wr_w, busy_w;
  logic [7:0] txd_w   [3];
  logic [7:0] err_w   [3];
  logic [4:0] pul_w   [3];
  logic [7:0] q0[$], q1[$], q2[$];
  int         pops[3], wrs[3], qms[3], pcyc[3], viol[3];
  logic [7:0] last_tx [3];
  int         n_chk = 0;
  int         n_err = 0;

  uart_cmd_decoder u_a (
    .clk(clk), .reset(reset), .fifo_rx_data(data_r[0]), .fifo_empty(empty_r[0]),
    .fifo_rd_en(rd_w[0]), .tx_full(tx_full), .tx_wr_en(wr_w[0]), .tx_data(txd_w[0]),
    .cmd_pulse(pul_w[0]), .err_cnt(err_w[0]), .busy(busy_w[0])
  );

  uart_cmd_decoder #(.PULSE_LEN(4), .CASE_FOLD(1'b0)) u_b (
    .clk(clk), .reset(reset), .fifo_rx_data(data_r[1]), .fifo_empty(empty_r[1]),
    .fifo_rd_en(rd_w[1]), .tx_full(tx_full), .tx_wr_en(wr_w[1]), .tx_data(txd_w[1]),
    .cmd_pulse(pul_w[1]), .err_cnt(err_w[1]), .busy(busy_w[1])
  );

  uart_cmd_decoder #(.PULSE_LEN(8), .ECHO_EN(1'b0)) u_c (
    .clk(clk), .reset(reset), .fifo_rx_data(data_r[2]), .fifo_empty(empty_r[2]),
    .fifo_rd_en(rd_w[2]), .tx_full(tx_full), .tx_wr_en(wr_w[2]), .tx_data(txd_w[2]),
    .cmd_pulse(pul_w[2]), .err_cnt(err_w[2]), .busy(busy_w[2])
  );

  // Show-ahead FIFO models: pop on rd_en, head and empty refreshed at each edge.
  always @(posedge clk) begin
    if (rd_w[0]) void'(q0.pop_front());
    if (rd_w[1]) void'(q1.pop_front());
    if (rd_w[2]) void'(q2.pop_front());
    empty_r   <= {q2.size() == 0, q1.size() == 0, q0.size() == 0};
    data_r[0] <= (q0.size() != 0) ? q0[0] : 8'h00;
    data_r[1] <= (q1.size() != 0) ? q1[0] : 8'h00;
    data_r[2] <= (q2.size() != 0) ? q2[0] : 8'h00;
  end

  // Per-instance activity counters and protocol-violation counts.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i]) pops[i] <= pops[i] + 1;
      if (wr_w[i]) begin
        wrs[i]     <= wrs[i] + 1;
        last_tx[i] <= txd_w[i];
        if (txd_w[i] == 8'h3F) qms[i] <= qms[i] + 1;
      end
      if (pul_w[i] != 5'b0) pcyc[i] <= pcyc[i] + 1;
      if ((rd_w[i] && empty_r[i]) || (wr_w[i] && tx_full) || !$onehot0(pul_w[i]))
        viol[i] <= viol[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input int i, input logic [7:0] b);
    case (i)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  function automatic int qsz(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic wait_rd(input int i);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!rd_w[i] && n < 20);
    check("pop_seen", 32'(rd_w[i]), 32'd1);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((qsz(i) != 0 || !empty_r[i] || busy_w[i]) && n < 3000);
    check("drain_idle", {30'd0, busy_w[i], ~empty_r[i]}, 32'd0);
  endtask

  initial begin
    int p0, w0, c0, q0m, c1, c4, other, f1, f4, nrd, nwr, nbit3;

    // Reset state
    repeat (3) step();
    check("rst_rd",    32'(rd_w[0]),   32'd0);
    check("rst_wr",    32'(wr_w[0]),   32'd0);
    check("rst_txd",   32'(txd_w[0]),  32'd0);
    check("rst_pulse", 32'(pul_w[0]),  32'd0);
    check("rst_err",   32'(err_w[0]),  32'd0);
    check("rst_busy",  32'(busy_w[0]), 32'd0);
    reset = 1'b0;
    step();

    // 'R' -> one pop, pulse bit0 two cycles later, echo 0x52
    push(0, 8'h52);
    wait_rd(0);
    step();
    check("R_n1_rd",    32'(rd_w[0]),   32'd0);
    check("R_n1_pulse", 32'(pul_w[0]),  32'd0);
    check("R_n1_busy",  32'(busy_w[0]), 32'd1);
    step();
    check("R_n2_pulse", 32'(pul_w[0]),  32'h01);
    step();
    check("R_n3_pulse", 32'(pul_w[0]),  32'h00);
    check("R_n3_wr",    32'(wr_w[0]),   32'd1);
    check("R_n3_txd",   32'(txd_w[0]),  32'h52);
    step();
    check("R_n4_busy",  32'(busy_w[0]), 32'd0);
    check("R_n4_wr",    32'(wr_w[0]),   32'd0);

    // 'h' folded to 'H' -> channel 2, echo 'H'
    push(0, 8'h68);
    wait_rd(0);
    step();
    step();
    check("h_fold_pulse", 32'(pul_w[0]), 32'h04);
    step();
    check("h_fold_wr",  32'(wr_w[0]),  32'd1);
    check("h_fold_txd", 32'(txd_w[0]), 32'h48);
    drain(0);

    // TX full stall after a hit on 'M', with 'S' waiting behind it
    tx_full = 1'b1;
    push(0, 8'h4D);
    push(0, 8'h53);
    wait_rd(0);
    nrd = 0; nwr = 0; nbit3 = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rd_w[0]) nrd++;
      if (wr_w[0]) nwr++;
      if (pul_w[0] == 5'b01000) nbit3++;
    end
    check("stall_busy",  32'(busy_w[0]), 32'd1);
    check("stall_nowr",  32'(nwr),       32'd0);
    check("stall_nopop", 32'(nrd),       32'd0);
    check("stall_pulse", 32'(nbit3),     32'd1);
    tx_full = 1'b0;
    #1;
    check("release_wr",  32'(wr_w[0]),  32'd1);
    check("release_txd", 32'(txd_w[0]), 32'h4D);
    step();
    check("release_wr_once", 32'(wr_w[0]), 32'd0);
    check("release_next_pop", 32'(rd_w[0]), 32'd1);
    drain(0);

    // CR and LF are consumed silently
    p0 = pops[0]; w0 = wrs[0]; c0 = pcyc[0];
    push(0, 8'h0D);
    push(0, 8'h0A);
    drain(0);
    check("eol_pops",  32'(pops[0] - p0), 32'd2);
    check("eol_wrs",   32'(wrs[0] - w0),  32'd0);
    check("eol_pulse", 32'(pcyc[0] - c0), 32'd0);
    check("eol_err",   32'(err_w[0]),     32'd0);

    // No case fold: 'h' misses
    push(1, 8'h68);
    wait_rd(1);
    step();
    check("h_nofold_pulse1", 32'(pul_w[1]), 32'd0);
    check("h_nofold_busy",   32'(busy_w[1]), 32'd1);
    step();
    check("h_nofold_wr",  32'(wr_w[1]),  32'd1);
    check("h_nofold_txd", 32'(txd_w[1]), 32'h3F);
    check("h_nofold_err", 32'(err_w[1]), 32'd1);
    check("h_nofold_pulse2", 32'(pul_w[1]), 32'd0);
    drain(1);

    // "CS" back to back, 4-cycle pulses: 'C' is table byte 1, 'S' is byte 4
    p0 = pops[1]; w0 = wrs[1];
    c1 = 0; c4 = 0; other = 0; f1 = -1; f4 = -1;
    push(1, 8'h43);
    push(1, 8'h53);
    for (int k = 0; k < 25; k++) begin
      step();
      if (pul_w[1] == 5'b00010) begin c1++; if (f1 < 0) f1 = k; end
      else if (pul_w[1] == 5'b10000) begin c4++; if (f4 < 0) f4 = k; end
      else if (pul_w[1] != 5'b0) other++;
    end
    check("cs_c_len",  32'(c1),    32'd4);
    check("cs_s_len",  32'(c4),    32'd4);
    check("cs_overlap", 32'(other), 32'd0);
    check("cs_order",  32'(f1 >= 0 && f1 < f4), 32'd1);
    check("cs_pops",   32'(pops[1] - p0), 32'd2);
    check("cs_wrs",    32'(wrs[1] - w0),  32'd2);
    check("cs_last_tx", 32'(last_tx[1]),  32'h53);
    drain(1);

    // Reset in the middle of an 8-cycle pulse
    push(2, 8'h52);
    push(2, 8'h52);
    wait_rd(2);
    step();
    step();
    check("mid_pulse_on", 32'(pul_w[2]), 32'h01);
    step();
    step();
    check("mid_pulse_still", 32'(pul_w[2]), 32'h01);
    reset = 1'b1;
    #1;
    check("rst_now_pulse", 32'(pul_w[2]), 32'd0);
    check("rst_now_rd",    32'(rd_w[2]),  32'd0);
    step();
    check("rst_edge_pulse", 32'(pul_w[2]),  32'd0);
    check("rst_edge_busy",  32'(busy_w[2]), 32'd0);
    check("rst_edge_rd",    32'(rd_w[2]),   32'd0);
    check("rst_edge_left",  32'(qsz(2)),    32'd1);
    reset = 1'b0;
    p0 = pops[2]; c0 = pcyc[2];
    drain(2);
    check("post_rst_pops",  32'(pops[2] - p0), 32'd1);
    check("post_rst_pulse", 32'(pcyc[2] - c0), 32'd8);
    check("noecho_wrs",     32'(wrs[2]),       32'd0);

    // 256 unmatched bytes: counter saturates, every one echoed as '?'
    w0 = wrs[0]; q0m = qms[0];
    for (int k = 0; k < 256; k++) push(0, 8'h58);
    drain(0);
    check("sat_err",   32'(err_w[0]),      32'd255);
    check("sat_wrs",   32'(wrs[0] - w0),   32'd256);
    check("sat_qmark", 32'(qms[0] - q0m),  32'd256);

    for (int i = 0; i < 3; i++) check($sformatf("protocol_%0d", i), 32'(viol[i]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
